// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared 32-bit carry-lookahead adder.
// Grants one of two requesters, executes for one full cycle, and holds the flagged result until accepted.
`timescale 1ns/1ps
module adder_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  input  logic        req1_cin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_ovf,
  output logic        res_zero,
  output logic        res_id,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        cin_q, cin_d, id_q, id_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_sum_q, res_sum_d;
  logic        res_cout_q, res_cout_d, res_ovf_q, res_ovf_d;
  logic        res_zero_q, res_zero_d, res_id_q, res_id_d;
  logic [15:0] ops_done_q, ops_done_d;

  logic        grant_id, accept;
  logic [31:0] sel_a, sel_b;
  logic [1:0]  sel_op;
  logic        sel_cin;
  logic [31:0] cla_sum;
  logic        cla_cout;

  // With both requesters valid, rr_ptr picks the winner; otherwise the lone requester wins.
  assign grant_id   = req1_valid & (~req0_valid | rr_ptr_q);
  assign accept     = (state_q == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~grant_id;
  assign req1_ready = (state_q == IDLE) & req1_valid & grant_id;

  assign sel_a   = grant_id ? req1_a   : req0_a;
  assign sel_b   = grant_id ? req1_b   : req0_b;
  assign sel_op  = grant_id ? req1_op  : req0_op;
  assign sel_cin = grant_id ? req1_cin : req0_cin;

  // The adder sees only the operand registers, giving the CLA path a whole cycle.
  always_comb begin : cla
    logic [31:0] g, p;
    logic [8:0]  gc;
    logic        grp_g, grp_p, c0, c1, c2, c3;
    g      = a_q & b_q;
    p      = a_q ^ b_q;
    gc     = '0;
    gc[0]  = cin_q;
    grp_g  = 1'b0;
    grp_p  = 1'b0;
    c0     = 1'b0;
    c1     = 1'b0;
    c2     = 1'b0;
    c3     = 1'b0;
    cla_sum = '0;
    for (int k = 0; k < 8; k++) begin
      grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      c0 = gc[k];
      c1 = g[4*k] | (p[4*k] & c0);
      c2 = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c0);
      c3 = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
         | (p[4*k+2] & p[4*k+1] & p[4*k] & c0);
      cla_sum[4*k +: 4] = p[4*k +: 4] ^ {c3, c2, c1, c0};
      gc[k+1] = grp_g | (grp_p & c0);
    end
    cla_cout = gc[8];
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    res_zero_d  = res_zero_q;
    res_id_d    = res_id_q;
    ops_done_d  = ops_done_q;
    unique case (state_q)
      IDLE: if (accept) begin
        a_d      = sel_a;
        b_d      = sel_op[1] ? ~sel_b : sel_b;
        cin_d    = sel_op[0] ? sel_cin : sel_op[1];
        id_d     = grant_id;
        rr_ptr_d = ~grant_id;
        state_d  = EXEC;
      end
      EXEC: begin
        res_sum_d   = cla_sum;
        res_cout_d  = cla_cout;
        res_ovf_d   = (a_q[31] == b_q[31]) & (cla_sum[31] != a_q[31]);
        res_zero_d  = (cla_sum == 32'd0);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (res_ready) begin
        res_valid_d = 1'b0;
        ops_done_d  = ops_done_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_zero_q  <= 1'b0;
      res_id_q    <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
      res_zero_q  <= res_zero_d;
      res_id_q    <= res_id_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_ovf   = res_ovf_q;
  assign res_zero  = res_zero_q;
  assign res_id    = res_id_q;
  assign ops_done  = ops_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against an arithmetic reference model.
`timescale 1ns/1ps
module tb_adder_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
  } req_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        res_valid, res_ready, res_cout, res_ovf, res_zero, res_id, busy;
  logic [31:0] res_sum;
  logic [15:0] ops_done;

  int          errors = 0;
  int          checks = 0;
  logic        favour;
  logic [15:0] exp_ops;
  longint      last_res_time;
  logic        last_id;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_ovf(res_ovf), .res_zero(res_zero), .res_id(res_id), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain integer arithmetic: ADD/ADDC add a carry, SUB/SUBB subtract a borrow.
  function automatic res_t model(input req_t r);
    res_t   o;
    longint ua, ub, us, sa, sb, ss, ci;
    ua = longint'(r.a);
    ub = longint'(r.b);
    sa = longint'($signed(r.a));
    sb = longint'($signed(r.b));
    if (!r.op[1]) begin
      ci = r.op[0] ? longint'(r.cin) : 0;
      us = ua + ub + ci;
      ss = sa + sb + ci;
      o.cout = (us >= 64'sh1_0000_0000);
    end else begin
      ci = r.op[0] ? longint'(!r.cin) : 0;
      us = ua - ub - ci;
      ss = sa - sb - ci;
      o.cout = (us >= 0);
    end
    o.sum  = us[31:0];
    o.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    o.zero = (o.sum == 32'd0);
    return o;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.a   = $urandom;
    r.b   = $urandom;
    r.op  = 2'($urandom_range(0, 3));
    r.cin = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Called on a falling edge with the DUT idle; returns on the falling edge of the next idle cycle.
  task automatic run_op(input bit v0, input req_t r0, input bit v1, input req_t r1, input int hold);
    logic exp_id;
    res_t e;
    req_valid_set(v0, r0, v1, r1);
    res_ready = 1'b0;
    #1;
    exp_id = (v0 && v1) ? favour : v1;
    check("ready0_idle", req0_ready, v0 && !exp_id);
    check("ready1_idle", req1_ready, v1 && exp_id);
    check("busy_idle", busy, 0);
    e = model(exp_id ? r1 : r0);
    favour = ~exp_id;
    @(negedge clk);
    check("busy_exec", busy, 1);
    check("valid_exec", res_valid, 0);
    check("ready_exec", {req0_ready, req1_ready}, 0);
    req_valid_set(v0, rand_req(), v1, rand_req());
    @(negedge clk);
    last_res_time = $time;
    last_id = exp_id;
    check("res_valid", res_valid, 1);
    check("res_sum", res_sum, e.sum);
    check("res_cout", res_cout, e.cout);
    check("res_ovf", res_ovf, e.ovf);
    check("res_zero", res_zero, e.zero);
    check("res_id", res_id, exp_id);
    check("ops_before", ops_done, exp_ops);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_sum", {res_sum, res_cout, res_ovf, res_zero, res_id},
            {e.sum, e.cout, e.ovf, e.zero, exp_id});
      check("hold_ready", {req0_ready, req1_ready}, 0);
      check("hold_ops", ops_done, exp_ops);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_ops = exp_ops + 16'd1;
    check("ops_after", ops_done, exp_ops);
    check("valid_after", res_valid, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic req_valid_set(input bit v0, input req_t r0, input bit v1, input req_t r1);
    req0_valid = v0; req0_a = r0.a; req0_b = r0.b; req0_op = r0.op; req0_cin = r0.cin;
    req1_valid = v1; req1_a = r1.a; req1_b = r1.b; req1_op = r1.op; req1_cin = r1.cin;
  endtask

  initial begin
    req_t z, r0, r1;
    longint prev_t;
    z = '0;
    rst = 1'b1;
    res_ready = 1'b0;
    req_valid_set(0, z, 0, z);
    favour = 1'b0;
    exp_ops = '0;
    #12;
    check("rst_valid", res_valid, 0);
    check("rst_outs", {res_sum, res_cout, res_ovf, res_zero, res_id}, 0);
    check("rst_ops", ops_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic corners.
    run_op(1, '{a: 32'hFFFF_FFFF, b: 32'h1, op: 2'b00, cin: 1'b0}, 0, z, 0);
    run_op(0, z, 1, '{a: 32'd5, b: 32'd7, op: 2'b10, cin: 1'b0}, 0);
    run_op(1, '{a: 32'd0, b: 32'd0, op: 2'b11, cin: 1'b0}, 0, z, 0);
    run_op(1, '{a: 32'h7FFF_FFFF, b: 32'h1, op: 2'b00, cin: 1'b0}, 0, z, 0);
    run_op(0, z, 1, '{a: 32'h8000_0000, b: 32'h8000_0000, op: 2'b01, cin: 1'b1}, 0);

    // Both requesters valid continuously: strict alternation, one result per 3 cycles.
    prev_t = 0;
    for (int i = 0; i < 8; i++) begin
      run_op(1, rand_req(), 1, rand_req(), 0);
      if (i > 0) begin
        check("alt_period", 64'(last_res_time - prev_t), 30);
      end
      prev_t = last_res_time;
    end

    // Back-pressure in DONE with both requesters waiting.
    run_op(1, rand_req(), 1, rand_req(), 5);
    r0 = rand_req();
    r1 = rand_req();
    run_op(1, r0, 1, r1, 0);

    // Reset while executing discards the operation.
    req_valid_set(1, '{a: 32'd10, b: 32'd20, op: 2'b00, cin: 1'b0}, 0, z);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    req_valid_set(0, z, 0, z);
    res_ready = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ops", ops_done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", res_valid, 0);
      check("post_rst_ops", ops_done, 0);
    end
    favour = 1'b0;
    exp_ops = '0;
    run_op(1, '{a: 32'd3, b: 32'd4, op: 2'b00, cin: 1'b0},
           1, '{a: 32'd3, b: 32'd4, op: 2'b00, cin: 1'b0}, 0);
    check("rst_add_id", last_id, 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      int v;
      v = int'($urandom_range(1, 3));
      run_op(v[0], rand_req(), v[1], rand_req(), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shared-adder controller for the 32-bit ALU: two requesters issue add/subtract operations to one 32-bit carry-lookahead adder (4-bit group generate/propagate, 8 group carries). The block arbitrates round-robin, registers the winning operands, runs the adder for one cycle, and holds a tagged result with flags until the consumer accepts it. It sits between the ALU operation sources and the result/flag writeback.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester 0/1 has an operation
- req0_ready / req1_ready  out  1  requester 0/1 accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_op / req1_op  in  2  00 ADD, 01 ADDC, 10 SUB, 11 SUBB
- req0_cin / req1_cin  in  1  carry-in for ADDC/SUBB (carry = not-borrow)
- res_valid  out  1  result held and valid
- res_ready  in  1  consumer accepts result
- res_sum  out  32  sum/difference
- res_cout  out  1  carry out of bit 31 (SUB: 1 = no borrow)
- res_ovf  out  1  signed overflow
- res_zero  out  1  res_sum == 0
- res_id  out  1  requester that issued the operation
- busy  out  1  state != IDLE
- ops_done  out  16  count of completed result handshakes, wraps 0xFFFF -> 0

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: grant is combinational. One valid -> that requester is granted. Both valid -> grant the requester selected by rr_ptr. Only the granted requester sees ready=1; neither ready when not in IDLE.
- Accept (valid&ready) -> latch a, b_eff, cin_eff, id into operand registers; rr_ptr <= ~id; go to EXEC. rr_ptr changes only on accept.
- Operand mapping: ADD b_eff=b, cin_eff=0; ADDC b_eff=b, cin_eff=cin; SUB b_eff=~b, cin_eff=1; SUBB b_eff=~b, cin_eff=cin.
- EXEC: adder is driven from the operand registers only, so the full CLA path gets one whole cycle. At the end of EXEC, capture {cout, sum}=a+b_eff+cin_eff; ovf=(a[31]==b_eff[31])&(sum[31]!=a[31]); zero=(sum==0); id. Go to DONE; res_valid <= 1.
- DONE: all res_* outputs are stable. A handshake (res_valid&res_ready) moves to IDLE, clears res_valid and increments ops_done. No handshake -> stay in DONE.
- Requester inputs are ignored outside the accept cycle. Operands may change freely after accept.

## Timing
- Reset values: state IDLE, rr_ptr 0 (requester 0 favoured), res_valid 0, res_sum 0, res_cout 0, res_ovf 0, res_zero 0, res_id 0, ops_done 0, busy 0, req*_ready 0 unless valid in IDLE.
- Accept in cycle T. State is EXEC in T+1. res_valid=1 from T+2.
- res_ready high in T+2 -> handshake at T+2, IDLE in T+3, next accept no earlier than T+3. Peak throughput is 1 op per 3 cycles.
- res_ready low -> DONE persists indefinitely, outputs do not change, ready stays 0 for both requesters. No request is dropped (requesters must hold valid).
- Simultaneous valids every IDLE -> grants alternate strictly. No starvation: a waiting requester is served within 2 grants.
- rst asserted in any state (including EXEC/DONE) -> immediate return to reset values. The in-flight operation is discarded and res_valid is never asserted for it.
- ops_done increments exactly once per result handshake and wraps silently.

## Test plan
- After reset, req0 ADD a=0xFFFFFFFF b=0x00000001 -> accepted first cycle; res_valid two cycles later with sum=0x00000000, cout=1, zero=1, ovf=0, id=0; ops_done=1 after handshake.
- req1 SUB a=5 b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0, id=1. req0 SUBB a=0 b=0 cin=0 -> sum=0xFFFFFFFF, cout=0.
- req0 ADD a=0x7FFFFFFF b=1 -> sum=0x80000000, ovf=1, cout=0. req1 ADDC a=0x80000000 b=0x80000000 cin=1 -> sum=0x00000001, cout=1, ovf=1.
- Both requesters valid continuously with res_ready=1 -> res_id sequence 0,1,0,1,... starting with 0 after reset; one result every 3 cycles.
- Hold res_ready=0 for 5 cycles in DONE with both valids high -> res_* constant, both ready=0, ops_done unchanged. Release -> exactly one increment, then the next grant.
- Assert rst during EXEC -> res_valid stays 0, ops_done=0. A subsequent ADD 3+4 returns sum=7, id of the requester granted with rr_ptr=0.
